// File: rtl/fib_pkg.sv
// fib_pkg: shared definitions for the Fibonacci sequencer slice.
//   state_t     - sequencer FSM states (3-bit encoding)
//   mux_sel_t   - datapath source select codes
//   DATA_WIDTH  - default width of the term value and LED display
package fib_pkg;

    localparam int unsigned DATA_WIDTH = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHOW  = 3'd2,
        WAIT  = 3'd3,
        ADD   = 3'd4,
        SHIFT = 3'd5,
        DONE  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        MUX_INIT = 2'd0,
        MUX_ADD  = 2'd1,
        MUX_MOVE = 2'd2
    } mux_sel_t;

endpackage

// File: rtl/fib_sequencer_if.sv
// fib_sequencer_if: control/status bundle between the sequencer and the
// gen_reg datapath plus display timer.
//   mux_sel_out   - datapath source select (INIT / ADD / MOVE)
//   x1..x4_set_out- register load strobes
//   t0_start_out  - one-cycle display timer start
//   zero_flag_in  - countdown register x4 is zero
//   carry_in      - carry-out of x1+x2
//   term_in       - current term (x2)
//   t0_int_in     - display timer expiry pulse
// master: sequencer side; slave: datapath/timer side.
interface fib_sequencer_if #(
    parameter int unsigned DATA_WIDTH = fib_pkg::DATA_WIDTH
);
    import fib_pkg::*;

    mux_sel_t              mux_sel_out;
    logic                  x1_set_out;
    logic                  x2_set_out;
    logic                  x3_set_out;
    logic                  x4_set_out;
    logic                  t0_start_out;
    logic                  zero_flag_in;
    logic                  carry_in;
    logic [DATA_WIDTH-1:0] term_in;
    logic                  t0_int_in;

    modport master (
        output mux_sel_out, x1_set_out, x2_set_out, x3_set_out, x4_set_out,
               t0_start_out,
        input  zero_flag_in, carry_in, term_in, t0_int_in
    );

    modport slave (
        input  mux_sel_out, x1_set_out, x2_set_out, x3_set_out, x4_set_out,
               t0_start_out,
        output zero_flag_in, carry_in, term_in, t0_int_in
    );

endinterface

// File: rtl/fib_sequencer.sv
// fib_sequencer: control FSM for the 4-bit Fibonacci register datapath.
// Initialises the operand registers, alternates add and shift steps, paces
// each displayed term with an external one-shot timer and latches the
// current term onto the LEDs.
//   clock_in  - system clock, rising edge
//   reset_in  - synchronous active-high reset
//   start_in  - start level, honoured only in IDLE and DONE
//   dp        - datapath/timer bundle (fib_sequencer_if.master)
//   led_out   - registered displayed term
//   busy_out  - high in every state except IDLE and DONE
//   done_out  - high in DONE
//   ovf_out   - sticky overflow flag
// Optional feature: define FIB_OVERFLOW_STOP_EN to stop the sequence on
// adder carry-out instead of letting the sum wrap.
module fib_sequencer
    import fib_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = fib_pkg::DATA_WIDTH
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic                  start_in,
    fib_sequencer_if.master       dp,
    output logic [DATA_WIDTH-1:0] led_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  ovf_out
);

`ifdef FIB_OVERFLOW_STOP_EN
    localparam bit OVF_STOP = 1'b1;
`else
    localparam bit OVF_STOP = 1'b0;
`endif

    state_t state;
    state_t next_state;
    logic   ovf_hit;

    // x1/x2 are stable from SHIFT through ADD, so the carry seen in WAIT is
    // the carry of the sum ADD would store.
    assign ovf_hit = OVF_STOP && dp.carry_in;

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start_in) next_state = LOAD;
            LOAD:    next_state = SHOW;
            SHOW:    next_state = WAIT;
            WAIT:    if (dp.t0_int_in) next_state = dp.zero_flag_in ? DONE : ADD;
            ADD:     next_state = ovf_hit ? DONE : SHIFT;
            SHIFT:   next_state = SHOW;
            DONE:    if (start_in) next_state = LOAD;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from next_state so each strobe is valid in
    // the cycle its state occupies.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state           <= IDLE;
            dp.mux_sel_out  <= MUX_INIT;
            dp.x1_set_out   <= 1'b0;
            dp.x2_set_out   <= 1'b0;
            dp.x3_set_out   <= 1'b0;
            dp.x4_set_out   <= 1'b0;
            dp.t0_start_out <= 1'b0;
            led_out         <= '0;
            busy_out        <= 1'b0;
            done_out        <= 1'b0;
            ovf_out         <= 1'b0;
        end else begin
            state <= next_state;

            unique case (next_state)
                ADD:     dp.mux_sel_out <= MUX_ADD;
                SHIFT:   dp.mux_sel_out <= MUX_MOVE;
                default: dp.mux_sel_out <= MUX_INIT;
            endcase

            dp.x1_set_out   <= (next_state == LOAD) || (next_state == SHIFT);
            dp.x2_set_out   <= (next_state == LOAD) || (next_state == SHIFT);
            dp.x4_set_out   <= (next_state == LOAD) || (next_state == SHIFT);
            // An overflowing sum is never written into x3.
            dp.x3_set_out   <= (next_state == LOAD) ||
                               ((next_state == ADD) && !ovf_hit);
            dp.t0_start_out <= (next_state == SHOW);
            busy_out        <= (next_state != IDLE) && (next_state != DONE);
            done_out        <= (next_state == DONE);

            if (state == SHOW) begin
                led_out <= dp.term_in;
            end

            if ((state == ADD) && ovf_hit) begin
                ovf_out <= 1'b1;
            end else if ((state == DONE) && start_in) begin
                ovf_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fib_sequencer.sv
// tb_fib_sequencer: self-checking bench for fib_sequencer with a behavioural
// gen_reg datapath and a display timer firing 4 cycles after each start.
// Expected terms are queued when a run is started and compared as each
// term reaches the LEDs. Honours FIB_OVERFLOW_STOP_EN like the design.
module tb_fib_sequencer;
    import fib_pkg::*;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_main;
    logic         start_stray = 1'b0;
    logic         start;
    logic [W-1:0] led;
    logic         busy;
    logic         done;
    logic         ovf;

    fib_sequencer_if #(.DATA_WIDTH(W)) dp_if ();

    fib_sequencer #(.DATA_WIDTH(W)) dut (
        .clock_in (clk),
        .reset_in (rst),
        .start_in (start),
        .dp       (dp_if),
        .led_out  (led),
        .busy_out (busy),
        .done_out (done),
        .ovf_out  (ovf)
    );

    always #5 clk = ~clk;

    assign start = start_main | start_stray;

    // Behavioural datapath: x1=F(n-1), x2=F(n), x3=sum, x4=countdown.
    logic [W-1:0] x1 = '0, x2 = '0, x3 = '0, x4 = '0;
    logic [W-1:0] init_count = '0;
    logic [W:0]   sum;
    assign sum = {1'b0, x1} + {1'b0, x2};

    always @(posedge clk) begin
        case (dp_if.mux_sel_out)
            MUX_INIT: begin
                if (dp_if.x1_set_out) x1 <= '0;
                if (dp_if.x2_set_out) x2 <= 1;
                if (dp_if.x3_set_out) x3 <= '0;
                if (dp_if.x4_set_out) x4 <= init_count;
            end
            MUX_ADD: begin
                if (dp_if.x3_set_out) x3 <= sum[W-1:0];
            end
            MUX_MOVE: begin
                if (dp_if.x1_set_out) x1 <= x2;
                if (dp_if.x2_set_out) x2 <= x3;
                if (dp_if.x4_set_out) x4 <= x4 - 1'b1;
            end
            default: ;
        endcase
    end

    // Timer model: fires one cycle, 4 cycles after t0_start.
    int   tcnt = 0;
    logic stray_int = 1'b0;
    always @(posedge clk) begin
        if (rst)                     tcnt <= 0;
        else if (dp_if.t0_start_out) tcnt <= 4;
        else if (tcnt > 0)           tcnt <= tcnt - 1;
    end

    assign dp_if.carry_in     = sum[W];
    assign dp_if.term_in      = x2;
    assign dp_if.zero_flag_in = (x4 == '0);
    assign dp_if.t0_int_in    = (tcnt == 1) | stray_int;

    // Records any attempt to store a carried (wrapped) sum into x3.
    logic wrapped_load = 1'b0;
    always @(posedge clk) begin
        if (dp_if.x3_set_out && dp_if.mux_sel_out == MUX_ADD && sum[W])
            wrapped_load <= 1'b1;
    end

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_val(input string tag, input int unsigned got,
                             input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Scoreboard: the term appears on led the cycle after SHOW.
    int unsigned exp_q[$];
    int unsigned pulses = 0;
    logic        show_d = 1'b0;
    always @(negedge clk) begin
        if (show_d) begin
            if (exp_q.size() == 0) check_val("term_unexpected", 1, 0);
            else                   check_val("term", led, exp_q.pop_front());
        end
        show_d = dp_if.t0_start_out;
        if (dp_if.t0_start_out) pulses++;
    end

    // Stray start/timer pulses while in ADD, SHIFT or SHOW.
    logic inject = 1'b0;
    always @(negedge clk) begin
        if (inject && ((dp_if.x3_set_out && dp_if.mux_sel_out == MUX_ADD) ||
                       (dp_if.x1_set_out && dp_if.mux_sel_out == MUX_MOVE) ||
                       dp_if.t0_start_out)) begin
            stray_int   = 1'b1;
            start_stray = 1'b1;
        end else begin
            stray_int   = 1'b0;
            start_stray = 1'b0;
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    function automatic int unsigned strobes();
        return {28'd0, dp_if.x1_set_out, dp_if.x2_set_out,
                dp_if.x3_set_out, dp_if.x4_set_out};
    endfunction

    // Queues the expected terms for a countdown value; returns count,
    // last term and the expected overflow flag.
    task automatic build_expected(input int unsigned count, output int unsigned n,
                                  output int unsigned last, output int unsigned e_ovf);
        int unsigned a = 0, b = 1, rem = count, s;
        n = 0;
        e_ovf = 0;
        exp_q.delete();
        while (1) begin
            exp_q.push_back(b);
            n++;
            last = b;
            if (rem == 0) break;
            s = a + b;
`ifdef FIB_OVERFLOW_STOP_EN
            if (s >= 16) begin
                e_ovf = 1;
                break;
            end
`endif
            a = b;
            b = s % 16;
            rem--;
        end
    endtask

    task automatic start_pulse(input int unsigned count);
        init_count   = count[W-1:0];
        pulses       = 0;
        wrapped_load = 1'b0;
        start_main   = 1'b1;
        tick;
        start_main   = 1'b0;
        check_val("load_mux", dp_if.mux_sel_out, MUX_INIT);
        check_val("load_strobes", strobes(), 4'hF);
        check_val("ovf_cleared", ovf, 0);
        tick;
        check_val("first_show", dp_if.t0_start_out, 1);
    endtask

    task automatic run(input int unsigned count);
        int unsigned n, last, e_ovf, cyc;
        build_expected(count, n, last, e_ovf);
        start_pulse(count);
        cyc = 0;
        while (!done && cyc < 2000) begin
            tick;
            cyc++;
        end
        check_val("done_seen", done, 1);
        repeat (3) tick;
        check_val("done_hold", done, 1);
        check_val("busy_done", busy, 0);
        check_val("led_hold", led, last);
        check_val("queue_empty", exp_q.size(), 0);
        check_val("pulse_count", pulses, n);
        check_val("ovf", ovf, e_ovf);
`ifdef FIB_OVERFLOW_STOP_EN
        check_val("no_wrapped_x3", wrapped_load, 0);
`endif
    endtask

    initial begin
        int unsigned n, last, e_ovf, cyc;
        rst        = 1'b1;
        start_main = 1'b0;
        repeat (3) tick;
        check_val("rst_led", led, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_ovf", ovf, 0);
        check_val("rst_mux", dp_if.mux_sel_out, MUX_INIT);
        check_val("rst_strobes", strobes(), 0);
        check_val("rst_t0", dp_if.t0_start_out, 0);
        rst = 1'b0;
        repeat (2) tick;
        check_val("idle_busy", busy, 0);

        run(5);
        run(10);
        run(0);

        inject = 1'b1;
        run(5);
        inject = 1'b0;

        // Reset while waiting on the third term.
        build_expected(5, n, last, e_ovf);
        start_pulse(5);
        cyc = 0;
        while (pulses < 3 && cyc < 200) begin
            tick;
            cyc++;
        end
        check_val("third_term_reached", pulses, 3);
        tick;
        check_val("in_wait_busy", busy, 1);
        check_val("in_wait_strobes", strobes(), 0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        exp_q.delete();
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_done", done, 0);
        check_val("mid_rst_led", led, 0);
        tick;
        check_val("mid_rst_idle", busy, 0);

        run(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fib_sequencer.md
# fib_sequencer

Control FSM that sequences the 4-bit Fibonacci register datapath: it initialises the operand registers, alternates add and shift steps, paces each displayed term with an external one-shot timer, and latches the current term onto the LEDs. The block sits between the top level and the `gen_reg` instances. It drives only set strobes, the datapath mux select and the timer start. It reads back the adder carry, the countdown zero flag and the term value.

## Interface
- `DATA_WIDTH`, 4, width of the term value and of `led_out`.
- `clock_in`  in  1  single system clock; all logic is rising-edge.
- `reset_in`  in  1  synchronous, active-high reset.
- `start_in`  in  1  level; sampled only in IDLE and DONE.
- `zero_flag_in`  in  1  countdown register x4 == 0.
- `carry_in`  in  1  adder carry-out of x1+x2.
- `term_in`  in  DATA_WIDTH  current x2 output.
- `t0_int_in`  in  1  display-timer expiry pulse.
- `mux_sel_out`  out  2  datapath source: INIT / ADD / MOVE.
- `x1_set_out`, `x2_set_out`, `x3_set_out`, `x4_set_out`  out  1 each  register load strobes.
- `t0_start_out`  out  1  one-cycle timer start pulse.
- `led_out`  out  DATA_WIDTH  registered displayed term.
- `busy_out`  out  1  high in every state except IDLE and DONE.
- `done_out`  out  1  high in DONE.
- `ovf_out`  out  1  sticky overflow indication.

## Operation
- Datapath contract:
  - x1 = F(n-1), x2 = F(n), x3 = sum, x4 = remaining-term countdown.
  - MUX_INIT loads the constants.
  - MUX_ADD routes x1+x2 to x3.
  - MUX_MOVE routes x2→x1, x3→x2 and x4−1→x4.
- IDLE: all strobes low. `start_in` → LOAD.
- LOAD: `mux_sel_out`=INIT; x1..x4 set high for one cycle. → SHOW.
- SHOW: `led_out` <= `term_in`; `t0_start_out`=1 for one cycle. → WAIT.
- WAIT: hold until `t0_int_in`=1. In that cycle, `zero_flag_in`=1 → DONE; otherwise → ADD.
- ADD: `mux_sel_out`=ADD; `x3_set_out`=1. → SHIFT. Carry handling is under Configuration.
- SHIFT: `mux_sel_out`=MOVE; x1, x2 and x4 set=1. → SHOW.
- DONE: `done_out`=1; `led_out` holds the last term. `start_in` → LOAD and clears `ovf_out`.
- `start_in` is ignored while `busy_out`=1.
- `t0_int_in` is ignored outside WAIT.
- `t0_int_in` and `start_in` arriving together in WAIT: timer event wins; start ignored.
- `reset_in` mid-operation: next edge → IDLE. The datapath is not re-initialised until the next LOAD.
- Reset values: all outputs 0, `mux_sel_out`=MUX_INIT, state IDLE.

## Timing
- The FSM is a registered state. Strobes and `mux_sel_out` decode from state (Moore), so they are valid in the state's own cycle.
- `led_out` is registered and updates on the edge that leaves SHOW.
- Start to first `t0_start_out`: 2 cycles (LOAD, SHOW).
- `t0_int_in` to next `t0_start_out`: 3 cycles (ADD, SHIFT, SHOW).
- Terms displayed = initial x4 + 1.
- No combinational path exists from any input to any output.

## Configuration
- `FIB_OVERFLOW_STOP_EN` defined:
  - In ADD with `carry_in`=1: `x3_set_out` is suppressed, `ovf_out` <= 1 (sticky), next state DONE.
  - `led_out` keeps the last valid term.
- Macro undefined:
  - `carry_in` is ignored and the sum wraps modulo 2^DATA_WIDTH.
  - `ovf_out` is tied 0.

## Structure
- Shared package `fib_pkg` holds:
  - state encoding: IDLE, LOAD, SHOW, WAIT, ADD, SHIFT, DONE (3 bits);
  - mux codes: MUX_INIT=2'd0, MUX_ADD=2'd1, MUX_MOVE=2'd2;
  - the default `DATA_WIDTH`.
- No sub-module: one FSM with a registered LED latch and overflow flag.

## Test plan
The bench uses a behavioural datapath model (x1=0, x2=1, x4=count at INIT) and a timer model that fires `t0_int_in` 4 cycles after `t0_start_out`.
- Reset, then hold `reset_in` for 3 cycles → all outputs 0, `mux_sel_out`=0, state IDLE.
- Count=5, pulse `start_in` → `led_out` sequence 1, 1, 2, 3, 5, 8, then `done_out`=1 and exactly 6 `t0_start_out` pulses.
- Count=10 with the macro defined → led 1, 1, 2, 3, 5, 8, 13, then DONE, `ovf_out`=1, x3 never loaded with a wrapped value. Without the macro → a 4'd5 (21 mod 16) term follows 13.
- `start_in` and stray `t0_int_in` pulses during ADD/SHIFT/SHOW → no state change; pulse count and sequence unchanged.
- `reset_in` asserted in WAIT after the third term → IDLE on the next edge. A restart reproduces 1, 1, 2, … from the beginning.
- Count=0 → a single term 1 is shown, then DONE. A new `start_in` in DONE restarts and clears `ovf_out`.
